// File: rtl/vx_fpu_rsp_arbiter.sv
// ============================================================================
// vx_fpu_rsp_arbiter : round-robin merge of FPU unit responses into one
//                      registered writeback port. Rev 1.0
// ============================================================================
`default_nettype none

module vx_fpu_rsp_arbiter #(
    parameter int NUM_REQS = 5,
    parameter int LANES    = 4,
    parameter int TAGW     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           valid_in,
    output logic [NUM_REQS-1:0]           ready_in,
    input  logic [NUM_REQS*LANES*32-1:0]  result_in,
    input  logic [NUM_REQS-1:0]           has_fflags_in,
    input  logic [NUM_REQS*LANES*5-1:0]   fflags_in,
    input  logic [NUM_REQS*TAGW-1:0]      tag_in,
    output logic                          valid_out,
    input  logic                          ready_out,
    output logic [LANES*32-1:0]           result,
    output logic                          has_fflags,
    output logic [LANES*5-1:0]            fflags,
    output logic [TAGW-1:0]               tag_out,
    output logic [$clog2(NUM_REQS)-1:0]   sel_out,
    output logic [31:0]                   perf_stalls
);

    localparam int SELW = $clog2(NUM_REQS);
    localparam int PW   = LANES * 32;
    localparam int FW   = LANES * 5;

    logic [SELW-1:0]     rr_ptr;
    logic [SELW-1:0]     grant_idx;
    logic [SELW-1:0]     next_ptr;
    logic [SELW-1:0]     scan_idx;
    logic [NUM_REQS-1:0] grant;
    logic                found;
    logic                load_en;
    int                  idx;

    // Output register is free when empty or being drained this cycle.
    assign load_en = !valid_out || ready_out;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQS) begin
                idx = idx - NUM_REQS;
            end
            scan_idx = SELW'(idx);
            if (!found && valid_in[scan_idx]) begin
                found           = 1'b1;
                grant[scan_idx] = 1'b1;
                grant_idx       = scan_idx;
            end
        end
    end

    assign ready_in = grant & {NUM_REQS{load_en}};
    assign next_ptr = (grant_idx == SELW'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out   <= 1'b0;
            result      <= '0;
            has_fflags  <= 1'b0;
            fflags      <= '0;
            tag_out     <= '0;
            sel_out     <= '0;
            rr_ptr      <= '0;
            perf_stalls <= '0;
        end else begin
            if (valid_out && !ready_out) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
            if (load_en) begin
                valid_out <= found;
                if (found) begin
                    result     <= result_in[int'(grant_idx) * PW +: PW];
                    has_fflags <= has_fflags_in[grant_idx];
                    fflags     <= fflags_in[int'(grant_idx) * FW +: FW];
                    tag_out    <= tag_in[int'(grant_idx) * TAGW +: TAGW];
                    sel_out    <= grant_idx;
                    rr_ptr     <= next_ptr;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vx_fpu_rsp_arbiter.sv
// ============================================================================
// tb_vx_fpu_rsp_arbiter : directed scoreboard bench for the FPU response
//                         arbiter. Rev 1.0
// ============================================================================
`default_nettype none

module tb_vx_fpu_rsp_arbiter;

    localparam int N  = 5;
    localparam int L  = 4;
    localparam int TW = 4;
    localparam int SW = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        valid_in;
    logic [N-1:0]        ready_in;
    logic [N*L*32-1:0]   result_in;
    logic [N-1:0]        has_fflags_in;
    logic [N*L*5-1:0]    fflags_in;
    logic [N*TW-1:0]     tag_in;
    logic                valid_out;
    logic                ready_out;
    logic [L*32-1:0]     result;
    logic                has_fflags;
    logic [L*5-1:0]      fflags;
    logic [TW-1:0]       tag_out;
    logic [SW-1:0]       sel_out;
    logic [31:0]         perf_stalls;

    vx_fpu_rsp_arbiter #(.NUM_REQS(N), .LANES(L), .TAGW(TW)) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_in),
        .ready_in      (ready_in),
        .result_in     (result_in),
        .has_fflags_in (has_fflags_in),
        .fflags_in     (fflags_in),
        .tag_in        (tag_in),
        .valid_out     (valid_out),
        .ready_out     (ready_out),
        .result        (result),
        .has_fflags    (has_fflags),
        .fflags        (fflags),
        .tag_out       (tag_out),
        .sel_out       (sel_out),
        .perf_stalls   (perf_stalls)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] sel;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t        sb[$];
    logic [TW-1:0] utag[N][8];
    int          uhead[N];
    int          ucnt[N];
    int          checks   = 0;
    int          failures = 0;

    // Payload encodes unit and tag so any mis-steered field is visible.
    function automatic logic [L*32-1:0] exp_res(input logic [SW-1:0] s, input logic [TW-1:0] t);
        logic [L*32-1:0] r;
        r = '0;
        for (int l = 0; l < L; l++) r[l*32 +: 32] = {8'hA5, 5'd0, s, 4'd0, t, 8'(l)};
        return r;
    endfunction

    function automatic logic [L*5-1:0] exp_ff(input logic [SW-1:0] s, input logic [TW-1:0] t);
        logic [L*5-1:0] f;
        f = '0;
        for (int l = 0; l < L; l++) f[l*5 +: 5] = 5'(int'(s) + int'(t) * 2 + l);
        return f;
    endfunction

    function automatic logic exp_hf(input logic [SW-1:0] s, input logic [TW-1:0] t);
        return t[0] ^ s[0];
    endfunction

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic enq(input int u, input logic [TW-1:0] t);
        utag[u][(uhead[u] + ucnt[u]) % 8] = t;
        ucnt[u]++;
    endtask

    task automatic push(input int s, input logic [TW-1:0] t);
        exp_t e;
        e.sel = SW'(s);
        e.tag = t;
        sb.push_back(e);
    endtask

    task automatic drive_units();
        logic [TW-1:0] t;
        for (int i = 0; i < N; i++) begin
            valid_in[i] = (ucnt[i] > 0);
            t = (ucnt[i] > 0) ? utag[i][uhead[i]] : '0;
            tag_in[i*TW +: TW]         = t;
            result_in[i*L*32 +: L*32]  = exp_res(SW'(i), t);
            fflags_in[i*L*5 +: L*5]    = exp_ff(SW'(i), t);
            has_fflags_in[i]           = exp_hf(SW'(i), t);
        end
    endtask

    // Checks any output leaving this cycle, advances one edge, then updates units.
    task automatic tick();
        logic [N-1:0] acc;
        exp_t         e;
        if (valid_out && ready_out) begin
            chk("out_expected", 256'(sb.size() != 0), 256'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_sel",    256'(sel_out),    256'(e.sel));
                chk("out_tag",    256'(tag_out),    256'(e.tag));
                chk("out_result", 256'(result),     256'(exp_res(e.sel, e.tag)));
                chk("out_fflags", 256'(fflags),     256'(exp_ff(e.sel, e.tag)));
                chk("out_hasff",  256'(has_fflags), 256'(exp_hf(e.sel, e.tag)));
            end
        end
        acc = valid_in & ready_in;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                uhead[i] = (uhead[i] + 1) % 8;
                ucnt[i]--;
            end
        end
        drive_units();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        ready_out = 1'b1;
        for (int i = 0; i < N; i++) begin
            uhead[i] = 0;
            ucnt[i]  = 0;
        end
        drive_units();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",  256'(valid_out),   256'(0));
        chk("rst_sel",    256'(sel_out),     256'(0));
        chk("rst_perf",   256'(perf_stalls), 256'(0));
        chk("rst_tag",    256'(tag_out),     256'(0));
        chk("rst_ready",  256'(ready_in),    256'(0));
        #1 reset = 1'b0;
        #1;

        // Reset while holding a stalled response.
        ready_out = 1'b0;
        enq(3, 4'd4);
        drive_units();
        #1;
        tick();
        chk("pre_rst_valid", 256'(valid_out), 256'(1));
        chk("pre_rst_sel",   256'(sel_out),   256'(3));
        tick();
        chk("pre_rst_perf",  256'(perf_stalls), 256'(1));
        reset = 1'b1;
        #1;
        chk("async_rst_valid",  256'(valid_out),   256'(0));
        chk("async_rst_sel",    256'(sel_out),     256'(0));
        chk("async_rst_perf",   256'(perf_stalls), 256'(0));
        chk("async_rst_result", 256'(result),      256'(0));
        @(posedge clk);
        #2;
        reset     = 1'b0;
        ready_out = 1'b1;
        enq(1, 4'd13);
        enq(4, 4'd14);
        push(1, 4'd13);
        push(4, 4'd14);
        drive_units();
        #1;
        repeat (3) tick();
        chk("post_rst_drained", 256'(sb.size()), 256'(0));

        // All units continuously valid.
        for (int i = 0; i < N; i++) begin
            enq(i, 4'(i + 1));
            enq(i, 4'(i + 8));
        end
        for (int i = 0; i < N; i++) push(i, 4'(i + 1));
        for (int i = 0; i < N; i++) push(i, 4'(i + 8));
        drive_units();
        #1;
        repeat (11) tick();
        chk("all_drained", 256'(sb.size()), 256'(0));

        // Single unit back-to-back, no bubbles.
        for (int t = 1; t <= 3; t++) begin
            enq(2, 4'(t));
            push(2, 4'(t));
        end
        drive_units();
        #1;
        repeat (4) tick();
        chk("single_drained", 256'(sb.size()), 256'(0));
        chk("single_idle",    256'(valid_out), 256'(0));
        chk("idle_ready",     256'(ready_in),  256'(0));

        // Pointer at 2 after unit 1: unit 3 goes before unit 1.
        enq(1, 4'd5);
        push(1, 4'd5);
        drive_units();
        #1;
        tick();
        enq(1, 4'd6);
        enq(3, 4'd7);
        push(3, 4'd7);
        push(1, 4'd6);
        drive_units();
        #1;
        repeat (3) tick();
        chk("rr_drained", 256'(sb.size()), 256'(0));

        // Wrap: after unit 4 the scan restarts at unit 0.
        enq(4, 4'd8);
        push(4, 4'd8);
        drive_units();
        #1;
        tick();
        enq(0, 4'd9);
        enq(4, 4'd10);
        push(0, 4'd9);
        push(4, 4'd10);
        drive_units();
        #1;
        repeat (3) tick();
        chk("wrap_drained", 256'(sb.size()), 256'(0));

        // Backpressure for three cycles.
        ready_out = 1'b0;
        enq(0, 4'd11);
        enq(2, 4'd12);
        push(0, 4'd11);
        push(2, 4'd12);
        drive_units();
        #1;
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("stall_ready", 256'(ready_in),  256'(0));
            chk("stall_valid", 256'(valid_out), 256'(1));
            chk("stall_sel",   256'(sel_out),   256'(0));
            chk("stall_tag",   256'(tag_out),   256'(11));
            chk("stall_res",   256'(result),    256'(exp_res(3'd0, 4'd11)));
            tick();
        end
        chk("stall_perf", 256'(perf_stalls), 256'(3));
        ready_out = 1'b1;
        #1;
        chk("release_ready", 256'(ready_in), 256'(5'b00100));
        repeat (2) tick();
        chk("bp_drained",   256'(sb.size()),   256'(0));
        chk("bp_idle",      256'(valid_out),   256'(0));
        chk("bp_perf_hold", 256'(perf_stalls), 256'(3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
